// File: rtl/can_register_bank.sv
// Register bank for the CAN controller map: RW, RO, W1C and COR registers
// with masked host writes, a registered read port and an aggregated irq.
module can_register_bank #(
    parameter int unsigned               WIDTH       = 8,
    parameter int unsigned               DEPTH       = 8,
    parameter int unsigned               AW          = 3,
    parameter logic [DEPTH*WIDTH-1:0]    RESET_VALUE = '0,
    parameter logic [2*DEPTH-1:0]        MODE        = '0,
    parameter int unsigned               U_DLY       = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rst_sync,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [WIDTH-1:0]         wr_mask,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     addr_err,
    input  logic [DEPTH*WIDTH-1:0]   hw_data,
    input  logic [DEPTH*WIDTH-1:0]   hw_set,
    output logic [DEPTH*WIDTH-1:0]   regs_out,
    output logic                     irq
);

    localparam logic [1:0] M_RW  = 2'b00;
    localparam logic [1:0] M_RO  = 2'b01;
    localparam logic [1:0] M_W1C = 2'b10;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_addr_err;
    logic             r_irq;

    logic [WIDTH-1:0] w_next [DEPTH];
    logic [WIDTH-1:0] w_rd_word;
    logic             w_irq_next;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_unused;

    assign w_wr_ok  = wr_en && (32'(wr_addr) < DEPTH);
    assign w_rd_ok  = rd_en && (32'(rd_addr) < DEPTH);
    // Not every mode consumes every hw_data / hw_set bit.
    assign w_unused = ^{hw_data, hw_set, U_DLY[0]};

    always_comb begin
        w_irq_next = 1'b0;
        w_rd_word  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            case (MODE[2*i +: 2])
                M_RW: begin
                    w_next[i] = (w_wr_ok && 32'(wr_addr) == i)
                              ? ((r_regs[i] & ~wr_mask) | (wr_data & wr_mask))
                              : r_regs[i];
                end
                M_RO: begin
                    w_next[i] = hw_data[i*WIDTH +: WIDTH];
                end
                M_W1C: begin
                    w_next[i] = (r_regs[i]
                              & ~(wr_data & wr_mask
                                  & {WIDTH{w_wr_ok && 32'(wr_addr) == i}}))
                              | hw_set[i*WIDTH +: WIDTH];
                    w_irq_next = w_irq_next | (|w_next[i]);
                end
                default: begin
                    w_next[i] = (r_regs[i]
                              & ~{WIDTH{w_rd_ok && 32'(rd_addr) == i}})
                              | hw_set[i*WIDTH +: WIDTH];
                    w_irq_next = w_irq_next | (|w_next[i]);
                end
            endcase
            // Read sees the current contents, before this cycle's update.
            if (w_rd_ok && 32'(rd_addr) == i) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RESET_VALUE[i*WIDTH +: WIDTH];
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
            r_irq      <= 1'b0;
        end else if (rst_sync) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[i] <= RESET_VALUE[i*WIDTH +: WIDTH];
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_regs     <= w_next;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
            r_addr_err <= (wr_en && !w_wr_ok) || (rd_en && !w_rd_ok);
            r_irq      <= w_irq_next;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign regs_out[g*WIDTH +: WIDTH] = r_regs[g];
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign addr_err = r_addr_err;
    assign irq      = r_irq;

endmodule

// File: tb/tb_can_register_bank.sv
// Bench for can_register_bank: directed cases plus a random soak,
// checked by a scoreboard queue and a behavioural register model.
module tb_can_register_bank;

    localparam int W  = 8;
    localparam int D  = 6;
    localparam int AW = 3;
    localparam logic [D*W-1:0] RV = {D{8'hA5}};
    // reg5 W1C, reg4 RW, reg3 COR, reg2 W1C, reg1 RO, reg0 RW
    localparam logic [2*D-1:0] MD = 12'b10_00_11_10_01_00;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst_sync = 1'b0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] wr_mask = '0;
    logic [D*W-1:0] hw_data = '0;
    logic [D*W-1:0] hw_set = '0;
    logic [W-1:0] rd_data;
    logic rd_valid;
    logic addr_err;
    logic irq;
    logic [D*W-1:0] regs_out;

    can_register_bank #(
        .WIDTH(W), .DEPTH(D), .AW(AW),
        .RESET_VALUE(RV), .MODE(MD), .U_DLY(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rst_sync(rst_sync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err),
        .hw_data(hw_data), .hw_set(hw_set), .regs_out(regs_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned c;
        logic        v;
        logic [W-1:0] d;
        logic        e;
    } exp_t;

    exp_t expq[$];
    logic [W-1:0] m_reg [D];
    logic m_irq = 1'b0;
    logic mon_en = 1'b0;
    logic [D*W-1:0] g_hd = '0;
    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [D*W-1:0] m_flat();
        logic [D*W-1:0] f;
        for (int i = 0; i < D; i++) f[i*W +: W] = m_reg[i];
        return f;
    endfunction

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        rst_sync = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        hw_set = '0; hw_data = g_hd;
        for (int i = 0; i < D; i++) m_reg[i] = RV[i*W +: W];
        m_irq = 1'b0;
        expq.delete();
        #1;
        chk("rst_regs", regs_out, RV);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_irq", irq, 0);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic we, input logic [AW-1:0] wa,
                        input logic [W-1:0] wd, input logic [W-1:0] wm,
                        input logic re, input logic [AW-1:0] ra,
                        input logic [D*W-1:0] hs, input logic rs);
        exp_t x;
        logic [W-1:0] old [D];
        wr_en = we; wr_addr = wa; wr_data = wd; wr_mask = wm;
        rd_en = re; rd_addr = ra; hw_set = hs; hw_data = g_hd;
        rst_sync = rs;
        @(posedge clk);
        #1;
        for (int i = 0; i < D; i++) old[i] = m_reg[i];
        x.c = cyc;
        x.v = re && !rs;
        x.d = (re && int'(ra) < D) ? old[int'(ra)] : '0;
        x.e = !rs && ((we && int'(wa) >= D) || (re && int'(ra) >= D));
        if (x.v || x.e) expq.push_back(x);
        if (rs) begin
            for (int i = 0; i < D; i++) m_reg[i] = RV[i*W +: W];
            m_irq = 1'b0;
        end else begin
            m_irq = 1'b0;
            for (int i = 0; i < D; i++) begin
                logic [W-1:0] s;
                logic wh;
                logic rh;
                s  = hs[i*W +: W];
                wh = we && int'(wa) == i;
                rh = re && int'(ra) == i;
                case (MD[2*i +: 2])
                    2'b00: if (wh) m_reg[i] = (old[i] & ~wm) | (wd & wm);
                    2'b01: m_reg[i] = g_hd[i*W +: W];
                    2'b10: m_reg[i] = (old[i] & ~(wh ? (wd & wm) : 8'h00)) | s;
                    default: m_reg[i] = (rh ? 8'h00 : old[i]) | s;
                endcase
                if (MD[2*i+1] && m_reg[i] != 0) m_irq = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic [W-1:0] m);
        step(1'b1, a, d, m, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, '0, '0, '0, 1'b1, a, '0, 1'b0);
    endtask

    task automatic idle(input logic [D*W-1:0] hs);
        step(1'b0, '0, '0, '0, 1'b0, '0, hs, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (expq.size() > 0 && expq[0].c < cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_resp: got none expected cycle %0d",
                             expq[0].c);
                    void'(expq.pop_front());
                end
                if (rd_valid || addr_err) begin
                    if (expq.size() == 0 || expq[0].c != cyc) begin
                        checks++; errors++;
                        $display("FAIL spurious_resp: got valid=%b err=%b expected none",
                                 rd_valid, addr_err);
                    end else begin
                        x = expq.pop_front();
                        chk("sb_rd_valid", rd_valid, x.v);
                        chk("sb_addr_err", addr_err, x.e);
                        if (x.v) chk("sb_rd_data", rd_data, x.d);
                    end
                end
                chk("model_regs", regs_out, m_flat());
                chk("model_irq", irq, m_irq);
            end
        end
    end

    initial begin
        g_hd = 48'h0000_0000_9600;
        do_reset();
        mon_en = 1'b1;

        rd(3);
        chk("reset_read_data", rd_data, 8'hA5);
        chk("reset_read_valid", rd_valid, 1);
        idle('0);
        chk("idle_valid", rd_valid, 0);
        chk("idle_hold", rd_data, 8'hA5);

        wr(0, 8'h00, 8'hFF);
        wr(0, 8'hFF, 8'h0F);
        chk("rw_mask_lo", regs_out[7:0], 8'h0F);
        wr(0, 8'h00, 8'hF0);
        chk("rw_mask_hold", regs_out[7:0], 8'h0F);

        wr(1, 8'hFF, 8'hFF);
        chk("ro_mirror", regs_out[15:8], 8'h96);
        chk("ro_no_err", addr_err, 0);

        wr(5, 8'hFF, 8'hFF);
        wr(2, 8'hFF, 8'hFF);
        chk("irq_clear", irq, 0);
        idle(48'h81 << 16);
        chk("w1c_set", regs_out[23:16], 8'h81);
        chk("irq_set", irq, 1);
        step(1'b1, 2, 8'h01, 8'hFF, 1'b0, 0, 48'h01 << 16, 1'b0);
        chk("w1c_race", regs_out[23:16], 8'h81);
        wr(2, 8'h80, 8'hFF);
        chk("w1c_clear", regs_out[23:16], 8'h01);
        chk("irq_partial", irq, 1);
        wr(2, 8'h01, 8'hFF);
        chk("irq_all_clear", irq, 0);

        idle(48'h3C << 24);
        wr(3, 8'hFF, 8'hFF);
        chk("cor_wr_ignored", regs_out[31:24], 8'h3C);
        rd(3);
        chk("cor_read", rd_data, 8'h3C);
        chk("cor_cleared", regs_out[31:24], 8'h00);
        step(1'b0, 0, 0, 0, 1'b1, 3, 48'h02 << 24, 1'b0);
        chk("cor_race_data", rd_data, 8'h00);
        chk("cor_race_reg", regs_out[31:24], 8'h02);

        wr(7, 8'hFF, 8'hFF);
        chk("oob_wr_regs", regs_out, 48'h00_A5_02_00_96_0F);
        chk("oob_wr_err", addr_err, 1);
        chk("oob_wr_valid", rd_valid, 0);
        rd(6);
        chk("oob_rd_data", rd_data, 8'h00);
        chk("oob_rd_valid", rd_valid, 1);
        chk("oob_rd_err", addr_err, 1);
        idle('0);
        chk("err_pulse", addr_err, 0);

        wr(4, 8'h11, 8'hFF);
        step(1'b1, 4, 8'h22, 8'hFF, 1'b1, 4, '0, 1'b0);
        chk("rw_same_rd", rd_data, 8'h11);
        chk("rw_same_reg", regs_out[39:32], 8'h22);

        step(1'b1, 0, 8'hFF, 8'hFF, 1'b1, 3, {D*W{1'b1}}, 1'b1);
        chk("sync_regs", regs_out, RV);
        chk("sync_irq", irq, 0);
        chk("sync_valid", rd_valid, 0);

        for (int n = 0; n < 500; n++) begin
            logic [D*W-1:0] hs;
            if (n % 16 == 0) g_hd = 48'({$urandom, $urandom});
            hs = 48'({$urandom, $urandom}) & 48'({$urandom, $urandom})
               & 48'({$urandom, $urandom});
            step(1'($urandom), AW'($urandom), W'($urandom), W'($urandom),
                 1'($urandom), AW'($urandom), hs,
                 $urandom_range(0, 39) == 0);
        end

        idle('0);
        @(negedge clk);
        #1;
        chk("queue_empty", expq.size(), 0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
